// File: rtl/gate_resp_misr.sv
// 9-bit MISR compactor for gate-model responses with a run FSM and golden compare.
// Optional GATE_RESP_MISR_MASK_EN adds resp_mask to blank X-prone response bits.
module gate_resp_misr #(
    parameter int unsigned PATTERNS = 256,
    parameter logic [8:0]  GOLDEN   = 9'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        resp_valid,
    input  logic [8:0]  resp,
`ifdef GATE_RESP_MISR_MASK_EN
    input  logic [8:0]  resp_mask,
`endif
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [8:0]  signature,
    output logic [15:0] count
);

    localparam int unsigned SW = 9;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sig_d;
    logic [CW-1:0] cnt_d;
    logic          pass_d;
    logic [SW-1:0] r_c;
    logic [SW-1:0] misr_c;
    logic [CW-1:0] cnt_inc_c;
    logic          last_c;

`ifdef GATE_RESP_MISR_MASK_EN
    assign r_c = resp & ~resp_mask;
`else
    assign r_c = resp;
`endif

    // Next MISR value for x^9 + x^4 + 1, feedback taken from the MSB.
    always_comb begin
        misr_c    = '0;
        misr_c[0] = signature[SW-1] ^ r_c[0];
        for (int i = 1; i < int'(SW); i++) begin
            misr_c[i] = signature[i-1] ^ r_c[i];
        end
        misr_c[4] = misr_c[4] ^ signature[SW-1];
    end

    assign cnt_inc_c = count + CW'(1);
    assign last_c    = (cnt_inc_c == CW'(PATTERNS));

    always_comb begin
        state_d = state_q;
        sig_d   = signature;
        cnt_d   = count;
        pass_d  = pass;
        case (state_q)
            IDLE, DONE: begin
                // A vector arriving with start is dropped; compaction begins next cycle.
                if (start) begin
                    state_d = RUN;
                    sig_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (resp_valid) begin
                    sig_d = misr_c;
                    cnt_d = cnt_inc_c;
                    if (last_c) begin
                        state_d = DONE;
                        pass_d  = (misr_c == GOLDEN);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sig_d   = '0;
                cnt_d   = '0;
                pass_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            signature <= '0;
            count     <= '0;
            pass      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            signature <= sig_d;
            count     <= cnt_d;
            pass      <= pass_d;
            busy      <= (state_d == RUN);
            done      <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_gate_resp_misr.sv
// Randomized bench for gate_resp_misr: three instances (PATTERNS 256/2/1) share stimulus
// and are compared every cycle against a polynomial-arithmetic reference model.
module tb_gate_resp_misr;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        resp_valid;
    logic [8:0]  resp;
    logic [8:0]  resp_mask;
    logic        busy_o [3];
    logic        done_o [3];
    logic        pass_o [3];
    logic [8:0]  sig_o  [3];
    logic [15:0] cnt_o  [3];

    int checks = 0;
    int errors = 0;

    int          pat  [3];
    logic [8:0]  gold [3];
    int          m_phase [3];   // 0 idle, 1 running, 2 finished
    logic [8:0]  m_sig [3];
    int          m_cnt [3];
    logic        m_pass [3];

    gate_resp_misr #(.PATTERNS(256), .GOLDEN(9'h000)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp(resp),
`ifdef GATE_RESP_MISR_MASK_EN
        .resp_mask(resp_mask),
`endif
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .signature(sig_o[0]), .count(cnt_o[0]));

    gate_resp_misr #(.PATTERNS(2), .GOLDEN(9'h011)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp(resp),
`ifdef GATE_RESP_MISR_MASK_EN
        .resp_mask(resp_mask),
`endif
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .signature(sig_o[1]), .count(cnt_o[1]));

    gate_resp_misr #(.PATTERNS(1), .GOLDEN(9'h001)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp(resp),
`ifdef GATE_RESP_MISR_MASK_EN
        .resp_mask(resp_mask),
`endif
        .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .signature(sig_o[2]), .count(cnt_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Signature as polynomial: multiply by x, add response, reduce modulo x^9+x^4+1.
    function automatic logic [8:0] poly_step(input logic [8:0] s, input logic [8:0] r);
        logic [9:0] t;
        t = {s, 1'b0} ^ {1'b0, r};
        if (t[9]) t = t ^ 10'h211;
        return t[8:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_phase[k] = 0; m_sig[k] = '0; m_cnt[k] = 0; m_pass[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [8:0] r;
`ifdef GATE_RESP_MISR_MASK_EN
        r = resp & ~resp_mask;
`else
        r = resp;
`endif
        for (int k = 0; k < 3; k++) begin
            if (m_phase[k] != 1) begin
                if (start) begin
                    m_phase[k] = 1; m_sig[k] = '0; m_cnt[k] = 0; m_pass[k] = 1'b0;
                end
            end else if (resp_valid) begin
                m_sig[k] = poly_step(m_sig[k], r);
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == pat[k]) begin
                    m_phase[k] = 2;
                    m_pass[k]  = (m_sig[k] == gold[k]);
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(m_phase[k] == 1));
            check($sformatf("done[%0d]", k), 32'(done_o[k]), 32'(m_phase[k] == 2));
            check($sformatf("pass[%0d]", k), 32'(pass_o[k]), 32'(m_pass[k]));
            check($sformatf("sig[%0d]", k),  32'(sig_o[k]),  32'(m_sig[k]));
            check($sformatf("cnt[%0d]", k),  32'(cnt_o[k]),  32'(m_cnt[k]));
        end
    endtask

    // Drive one cycle of stimulus, advance the model on the edge, compare on the falling edge.
    task automatic tick(input logic st, input logic v, input logic [8:0] r);
        start = st; resp_valid = v; resp = r;
        @(posedge clk);
        if (rst_n) model_edge(); else model_reset();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick(1'b0, 1'b0, 9'h0);
        tick(1'b1, 1'b1, 9'h1ff);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        pat[0] = 256;  pat[1] = 2;       pat[2] = 1;
        gold[0] = 9'h000; gold[1] = 9'h011; gold[2] = 9'h001;
        start = 1'b0; resp_valid = 1'b0; resp = '0; resp_mask = '0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all();
        do_reset();

        // PATTERNS=1 instance: a single 0x001 vector finishes with pass.
        tick(1'b1, 1'b0, 9'h0);
        tick(1'b0, 1'b1, 9'h001);
        check("p1_sig", 32'(sig_o[2]), 32'h001);
        check("p1_done", 32'(done_o[2]), 32'd1);
        check("p1_pass", 32'(pass_o[2]), 32'd1);

        // PATTERNS=2 instance: 0x100 then 0x000 gives 0x100 then 0x011.
        do_reset();
        tick(1'b1, 1'b1, 9'h0ff);
        tick(1'b0, 1'b1, 9'h100);
        check("p2_sig1", 32'(sig_o[1]), 32'h100);
        check("p2_done1", 32'(done_o[1]), 32'd0);
        tick(1'b0, 1'b1, 9'h000);
        check("p2_sig2", 32'(sig_o[1]), 32'h011);
        check("p2_cnt", 32'(cnt_o[1]), 32'd2);
        check("p2_done2", 32'(done_o[1]), 32'd1);
        check("p2_pass", 32'(pass_o[1]), 32'd1);
        // Start in DONE restarts from zero.
        tick(1'b1, 1'b0, 9'h0);
        check("p2_restart_cnt", 32'(cnt_o[1]), 32'd0);
        check("p2_restart_busy", 32'(busy_o[1]), 32'd1);

        // Valid toggling every other cycle: 256 valids to finish.
        do_reset();
        tick(1'b1, 1'b0, 9'h0);
        for (int i = 0; i < 520; i++) tick(1'b0, 1'(i % 2), 9'($urandom));
        check("p256_cnt", 32'(cnt_o[0]), 32'd256);
        check("p256_done", 32'(done_o[0]), 32'd1);

        // Async reset mid-run at count 100, then a clean rerun.
        do_reset();
        tick(1'b1, 1'b0, 9'h0);
        guard = 0;
        while (m_cnt[0] != 100 && guard < 300) begin
            tick(1'b0, 1'b1, 9'($urandom));
            guard++;
        end
        check("reach_100", 32'(cnt_o[0]), 32'd100);
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        check("async_busy", 32'(busy_o[0]), 32'd0);
        check("async_sig", 32'(sig_o[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 9'h0);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 9'($urandom));

        // Start pulsed while running is ignored.
        tick(1'b1, 1'b1, 9'h155);
        check("start_in_run_cnt", 32'(cnt_o[0]), 32'd21);

`ifdef GATE_RESP_MISR_MASK_EN
        // Fully masked responses compact to zero and pass against GOLDEN=0.
        do_reset();
        resp_mask = 9'h1ff;
        tick(1'b1, 1'b0, 9'h0);
        for (int i = 0; i < 256; i++) tick(1'b0, 1'b1, 9'($urandom));
        check("mask_sig", 32'(sig_o[0]), 32'd0);
        check("mask_pass", 32'(pass_o[0]), 32'd1);
`endif

        // Long random run: sparse starts, random valids and responses.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
`ifdef GATE_RESP_MISR_MASK_EN
            resp_mask = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h0;
`endif
            tick(1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 2) != 0), 9'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
